alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_core.sv | 56 +++++
 rtl/alu_mc.sv | 119 +++++++++++
 tb/tb_alu_mc.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings and FSM state type for the multi-cycle ALU.
// The ALU decoder uses the same encodings.
package alu_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_BNE  = 4'd10,
    ALU_BLT  = 4'd11,
    ALU_BGE  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle arithmetic, logic, compare and branch evaluation.
// Shift codes pass operand A through; the iterative shifter lives in alu_mc.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  logic [XLEN-1:0] diff;
  logic            lt_s;
  logic            lt_u;

  assign diff = a - b;
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    result       = '0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB: begin
        result       = diff;
        branch_taken = (a == b);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_SLL, ALU_SRL, ALU_SRA: result = a;
      ALU_BNE: begin
        result       = diff;
        branch_taken = (a != b);
      end
      ALU_BLT: begin
        result       = diff;
        branch_taken = lt_s;
      end
      ALU_BGE: begin
        result       = diff;
        branch_taken = !lt_s;
      end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready handshake, one-bit-per-cycle shifter, and
// registered outputs held until the consumer accepts them.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            branch_taken,
  output logic            illegal
);

  alu_state_e       state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [XLEN-1:0]  result_q;
  logic             zero_q, br_q, ill_q;

  logic [XLEN-1:0]  core_result;
  logic             core_br, core_ill;
  logic [XLEN-1:0]  sh_nxt;
  logic             accept, start_shift;

  alu_core #(.XLEN(XLEN)) u_core (
    .op           (ALUControl),
    .a            (src_a),
    .b            (src_b),
    .result       (core_result),
    .branch_taken (core_br),
    .illegal      (core_ill)
  );

  assign accept      = in_valid && in_ready;
  assign start_shift = is_shift(ALUControl) && (src_b[SHAMT_W-1:0] != '0);

  always_comb begin
    case (op_q)
      ALU_SLL: sh_nxt = {result_q[XLEN-2:0], 1'b0};
      ALU_SRA: sh_nxt = {result_q[XLEN-1], result_q[XLEN-1:1]};
      default: sh_nxt = {1'b0, result_q[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = start_shift ? SHIFT : DONE;
      end
      SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The shift value is staged in result_q; out_valid gates its visibility.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= ALUControl;
          if (start_shift) begin
            cnt      <= src_b[SHAMT_W-1:0];
            result_q <= src_a;
            zero_q   <= 1'b0;
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
          end else begin
            cnt      <= '0;
            result_q <= core_result;
            zero_q   <= (core_result == '0);
            br_q     <= core_br;
            ill_q    <= core_ill;
          end
        end
        SHIFT: begin
          cnt      <= cnt - SHAMT_W'(1);
          result_q <= sh_nxt;
          if (cnt == SHAMT_W'(1)) zero_q <= (sh_nxt == '0);
        end
        default: ;
      endcase
    end
  end

  assign result       = result_q;
  assign zero         = zero_q;
  assign branch_taken = br_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] src_a, src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, branch_taken, illegal;

  int tests = 0;
  int fails = 0;

  alu_mc #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ALUControl   (ALUControl),
    .src_a        (src_a),
    .src_b        (src_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic br, output logic ill,
                                output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'h0;
    br  = 1'b0;
    ill = 1'b0;
    lat = 1;
    case (op)
      4'd0:  r = a + b;
      4'd1:  begin r = a - b; br = (a == b); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  r = (a < b) ? 32'd1 : 32'd0;
      4'd7:  begin r = a << sh; lat = 1 + sh; end
      4'd8:  begin r = a >> sh; lat = 1 + sh; end
      4'd9:  begin r = $signed(a) >>> sh; lat = 1 + sh; end
      4'd10: begin r = a - b; br = (a != b); end
      4'd11: begin r = a - b; br = ($signed(a) < $signed(b)); end
      4'd12: begin r = a - b; br = ($signed(a) >= $signed(b)); end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] er;
    logic        eb, ei;
    int          el, lat;
    model(op, a, b, er, eb, ei, el);
    ALUControl = op; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // Busy-time input noise must be ignored.
    ALUControl = 4'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("result", result, er);
    chk("zero", 32'(zero), 32'(er == 32'h0));
    chk("branch_taken", 32'(branch_taken), 32'(eb));
    chk("illegal", 32'(illegal), 32'(ei));
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result", result, er);
      chk("hold_zero", 32'(zero), 32'(er == 32'h0));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUControl = 4'd0; src_a = 32'h0; src_b = 32'h0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_branch", 32'(branch_taken), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);

    run_op(4'd1, 32'd5, 32'd5, 0);                   // sub equal
    run_op(4'd9, 32'h8000_0000, 32'd4, 0);           // sra, latency 5
    run_op(4'd11, 32'hFFFF_FFFF, 32'd1, 0);          // blt
    run_op(4'd12, 32'hFFFF_FFFF, 32'd1, 0);          // bge
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 0);           // sltu
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 3);           // add wrap, held
    run_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 1);  // illegal
    run_op(4'd7, 32'hDEAD_BEEF, 32'h20, 0);          // sll shamt 0
    run_op(4'd8, 32'h8000_0001, 32'd31, 0);          // srl max
    run_op(4'd5, 32'h8000_0000, 32'd1, 0);           // slt signed

    // Reset mid-shift discards the operation.
    ALUControl = 4'd7; src_a = 32'h0000_0001; src_b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_branch", 32'(branch_taken), 32'd0);
    chk("midrst_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("midrst_no_stale", 32'(seen), 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(op, a, b, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
